// File: rtl/ppm_mary_frame_encoder.sv
// ppm_mary_frame_fifo: generic synchronous FIFO, head word visible combinationally.
// Latency: a written word is readable the cycle after the write edge.
// Backpressure: o_wr_rdy low when full; a write into a full FIFO is refused even when a read happens in the same cycle.
module ppm_mary_frame_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_wr_vld,
    input  logic [W-1:0] i_wr_dat,
    output logic         o_wr_rdy,
    input  logic         i_rd_rdy,
    output logic         o_rd_vld,
    output logic [W-1:0] o_rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_wr_rdy = (r_cnt != (AW+1)'(DEPTH));
    assign o_rd_vld = (r_cnt != '0);
    assign w_push   = i_wr_vld && o_wr_rdy;
    assign w_pop    = i_rd_rdy && o_rd_vld;
    assign o_rd_dat = r_mem[r_rd_ptr];

    // Storage array; contents are meaningless while the count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// ppm_mary_frame_encoder: M-ary PPM framer, bytes -> SOF, data symbols, EOF, idle gap on a low-pulse line.
// Latency: start condition seen at an edge puts the first SOF slot on dout at the next edge.
// Backpressure: s_ready = FIFO not full; the line side never stalls, an empty FIFO mid-frame truncates the frame.
module ppm_mary_frame_encoder #(
    parameter int                BITS_PER_SYM = 2,
    parameter int                SLOT_CYCLES  = 4,
    parameter int                FIFO_DEPTH   = 16,
    parameter int                PAT_LEN      = 8,
    parameter logic [PAT_LEN-1:0] SOF_PAT     = 8'b11011101,
    parameter logic [PAT_LEN-1:0] EOF_PAT     = 8'b10111011,
    parameter int                GAP_SLOTS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       dout,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);
    localparam int NSLOT    = 1 << BITS_PER_SYM;
    localparam int NSYM     = 8 / BITS_PER_SYM;
    localparam int SMAX_A   = (PAT_LEN > NSLOT) ? PAT_LEN : NSLOT;
    localparam int SLOT_MAX = (SMAX_A > GAP_SLOTS) ? SMAX_A : GAP_SLOTS;
    localparam int SLOT_W   = $clog2(SLOT_MAX);
    localparam int CYC_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SYM_W    = 3;
    localparam int PEND_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [PAT_LEN-1:0] PAT_MSB = PAT_LEN'(1) << (PAT_LEN - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF, ST_GAP} state_t;

    state_t              r_state, w_state_nxt;
    logic [CYC_W-1:0]    r_cyc;
    logic [SLOT_W-1:0]   r_slot, w_slot_nxt;
    logic [SYM_W-1:0]    r_sym, w_sym_nxt;
    logic [8:0]          r_byte, w_byte_nxt;   // {last, data} of the byte on the line
    logic [PEND_W-1:0]   r_pending;
    logic                r_dout, w_dout_nxt;
    logic                r_frame_done, w_fd_nxt;
    logic                r_underrun, w_ur_nxt;
    logic                w_slot_end, w_pop, w_push;
    logic                w_fifo_rdy, w_fifo_vld;
    logic [8:0]          w_fifo_dat;
    logic [BITS_PER_SYM-1:0] w_symval;

    ppm_mary_frame_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_wr_vld (s_valid),
        .i_wr_dat ({s_last, s_data}),
        .o_wr_rdy (w_fifo_rdy),
        .i_rd_rdy (w_pop),
        .o_rd_vld (w_fifo_vld),
        .o_rd_dat (w_fifo_dat)
    );

    assign s_ready    = w_fifo_rdy;
    assign w_push     = s_valid && w_fifo_rdy;
    assign w_slot_end = (r_cyc == CYC_W'(SLOT_CYCLES - 1));
    assign w_symval   = BITS_PER_SYM'(w_byte_nxt[7:0] >> (w_sym_nxt * BITS_PER_SYM));

    // Next state and slot/symbol position; everything advances only on a slot boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_sym_nxt   = r_sym;
        w_byte_nxt  = r_byte;
        w_pop       = 1'b0;
        w_fd_nxt    = 1'b0;
        w_ur_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A full FIFO starts a frame without a last byte (cut-through).
                if (r_pending != '0 || !w_fifo_rdy) begin
                    w_state_nxt = ST_SOF;
                    w_slot_nxt  = '0;
                end
            end
            ST_SOF: begin
                if (w_slot_end) begin
                    if (r_slot == SLOT_W'(PAT_LEN - 1)) begin
                        w_slot_nxt = '0;
                        w_sym_nxt  = '0;
                        if (w_fifo_vld) begin
                            w_state_nxt = ST_DATA;
                            w_byte_nxt  = w_fifo_dat;
                            w_pop       = 1'b1;
                        end else begin
                            w_state_nxt = ST_EOF;
                            w_ur_nxt    = 1'b1;
                        end
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_slot_end) begin
                    if (r_slot == SLOT_W'(NSLOT - 1)) begin
                        w_slot_nxt = '0;
                        if (r_sym == SYM_W'(NSYM - 1)) begin
                            w_sym_nxt = '0;
                            if (r_byte[8]) begin
                                w_state_nxt = ST_EOF;
                            end else if (w_fifo_vld) begin
                                w_byte_nxt = w_fifo_dat;
                                w_pop      = 1'b1;
                            end else begin
                                w_state_nxt = ST_EOF;
                                w_ur_nxt    = 1'b1;
                            end
                        end else begin
                            w_sym_nxt = r_sym + 1'b1;
                        end
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            end
            ST_EOF: begin
                if (w_slot_end) begin
                    if (r_slot == SLOT_W'(PAT_LEN - 1)) begin
                        w_state_nxt = ST_GAP;
                        w_slot_nxt  = '0;
                        w_fd_nxt    = 1'b1;
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (w_slot_end) begin
                    if (r_slot == SLOT_W'(GAP_SLOTS - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_slot_nxt  = '0;
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line level derived from the next position so dout stays aligned with the state register.
    always_comb begin
        w_dout_nxt = 1'b1;
        case (w_state_nxt)
            ST_SOF:  w_dout_nxt = |((SOF_PAT << w_slot_nxt) & PAT_MSB);
            ST_DATA: w_dout_nxt = (w_slot_nxt != SLOT_W'(w_symval));
            ST_EOF:  w_dout_nxt = |((EOF_PAT << w_slot_nxt) & PAT_MSB);
            default: w_dout_nxt = 1'b1;
        endcase
    end

    // State register, slot timer, registered line and pulse outputs, frame accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cyc        <= '0;
            r_slot       <= '0;
            r_sym        <= '0;
            r_byte       <= '0;
            r_pending    <= '0;
            r_dout       <= 1'b1;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cyc        <= (r_state == ST_IDLE || w_slot_end) ? '0 : r_cyc + 1'b1;
            r_slot       <= w_slot_nxt;
            r_sym        <= w_sym_nxt;
            r_byte       <= w_byte_nxt;
            r_pending    <= r_pending + PEND_W'(w_push && s_last) - PEND_W'(w_pop && w_fifo_dat[8]);
            r_dout       <= w_dout_nxt;
            r_frame_done <= w_fd_nxt;
            r_underrun   <= w_ur_nxt;
        end
    end

    assign dout       = r_dout;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;
endmodule

// File: tb/tb_ppm_mary_frame_encoder.sv
// Bench for ppm_mary_frame_encoder: default instance (A) and a 1-bit/1-cycle-slot instance (B).
// Expected line waveforms come from a slot-list model built from the framing rules.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_ppm_mary_frame_encoder;
    typedef logic [7:0] byte_q_t[$];
    typedef bit bitq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_valid, a_ready, a_last, a_dout, a_busy, a_fd, a_ur;
    logic [7:0] a_data;
    logic       b_rst, b_valid, b_ready, b_last, b_dout, b_busy, b_fd, b_ur;
    logic [7:0] b_data;

    ppm_mary_frame_encoder u_dut_a (
        .clk(clk), .rst(a_rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
        .s_last(a_last), .dout(a_dout), .busy(a_busy), .frame_done(a_fd), .underrun(a_ur)
    );

    ppm_mary_frame_encoder #(.BITS_PER_SYM(1), .SLOT_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .s_last(b_last), .dout(b_dout), .busy(b_busy), .frame_done(b_fd), .underrun(b_ur)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int push_to = 0;
    bit cap_a[$];
    bit cap_b[$];
    int fd_a = 0, ur_a = 0, fd_b = 0, ur_b = 0;

    // Record the line while each instance is busy, and count the pulses.
    always @(negedge clk) begin
        if (a_busy === 1'b1) cap_a.push_back(a_dout);
        if (b_busy === 1'b1) cap_b.push_back(b_dout);
        if (a_fd === 1'b1) fd_a++;
        if (a_ur === 1'b1) ur_a++;
        if (b_fd === 1'b1) fd_b++;
        if (b_ur === 1'b1) ur_b++;
    end

    // Expected busy-period waveform: list of slot levels, each stretched to sc cycles.
    function automatic bitq_t frame_model(byte_q_t d, int b, int sc);
        logic [7:0] sof = 8'b11011101;
        logic [7:0] eof = 8'b10111011;
        bitq_t slots;
        bitq_t out;
        int v;
        for (int k = 0; k < 8; k++) slots.push_back(sof[7-k]);
        foreach (d[i]) begin
            for (int j = 0; j < 8 / b; j++) begin
                v = (int'(d[i]) >> (j * b)) % (1 << b);
                for (int s = 0; s < (1 << b); s++) slots.push_back(s != v);
            end
        end
        for (int k = 0; k < 8; k++) slots.push_back(eof[7-k]);
        for (int g = 0; g < 4; g++) slots.push_back(1'b1);
        foreach (slots[i]) repeat (sc) out.push_back(slots[i]);
        return out;
    endfunction

    function automatic int cap_size(int sel);
        return (sel == 0) ? cap_a.size() : cap_b.size();
    endfunction

    function automatic bit cap_at(int sel, int i);
        return (sel == 0) ? cap_a[i] : cap_b[i];
    endfunction

    // Index of the first differing cycle after base, or -1 when identical.
    function automatic int first_diff(int sel, int base, bitq_t exp);
        int n = cap_size(sel) - base;
        for (int i = 0; i < n && i < exp.size(); i++)
            if (cap_at(sel, base + i) != exp[i]) return i;
        if (n != exp.size()) return (n < exp.size()) ? n : exp.size();
        return -1;
    endfunction

    function automatic logic ready_of(int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic busy_of(int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    task automatic idle_now(input int sel);
        if (sel == 0) begin a_valid = 1'b0; a_last = 1'b0; end
        else begin b_valid = 1'b0; b_last = 1'b0; end
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        idle_now(sel);
    endtask

    // Offer one byte; returns just after the accepting clock edge.
    task automatic push(input int sel, input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        if (sel == 0) begin a_valid = 1'b1; a_data = d; a_last = l; end
        else begin b_valid = 1'b1; b_data = d; b_last = l; end
        while (ready_of(sel) !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (ready_of(sel) !== 1'b1) begin
            push_to++;
            idle_now(sel);
        end
        @(posedge clk);
    endtask

    // Wait for busy to be seen high and then low again, both bounded.
    task automatic wait_frame(input int sel, output bit ok);
        int t = 0;
        ok = 1'b1;
        @(negedge clk);
        while (busy_of(sel) !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        if (busy_of(sel) !== 1'b1) ok = 1'b0;
        else begin
            t = 0;
            while (busy_of(sel) !== 1'b0 && t < 8000) begin @(negedge clk); t++; end
            if (busy_of(sel) !== 1'b0) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        idle_now(0); idle_now(1);
        a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (a_dout !== 1'b1)  begin n_fail++; $display("FAIL reset_dout_a: got %b required 1", a_dout); end
        n_tests++; if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy_a: got %b required 0", a_busy); end
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %b required 1", a_ready); end
        n_tests++; if (a_fd !== 1'b0)    begin n_fail++; $display("FAIL reset_fd_a: got %b required 0", a_fd); end
        n_tests++; if (a_ur !== 1'b0)    begin n_fail++; $display("FAIL reset_ur_a: got %b required 0", a_ur); end
        n_tests++; if (b_dout !== 1'b1 || b_ready !== 1'b1)
            begin n_fail++; $display("FAIL reset_b: got dout=%b ready=%b required 1 1", b_dout, b_ready); end
        a_rst = 1'b0; b_rst = 1'b0;
    endtask

    task automatic test_single_byte();
        int base = cap_a.size();
        int fd0 = fd_a, ur0 = ur_a, d;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        q.push_back(8'hE4);
        exp = frame_model(q, 2, 4);
        push(0, 8'hE4, 1'b1);
        @(negedge clk);
        idle_now(0);
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL t1_latency_early: busy got %b required 0", a_busy); end
        @(negedge clk);
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL t1_latency_start: busy got %b required 1", a_busy); end
        wait_frame(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_timeout: busy got %b required frame end", a_busy); end
        d = first_diff(0, base, exp);
        n_tests++; if (d >= 0) begin n_fail++;
            $display("FAIL t1_frame: first diff at cycle %0d, captured %0d cycles required %0d", d, cap_a.size() - base, exp.size()); end
        n_tests++; if (fd_a - fd0 != 1) begin n_fail++; $display("FAIL t1_frame_done: got %0d pulses required 1", fd_a - fd0); end
        n_tests++; if (ur_a - ur0 != 0) begin n_fail++; $display("FAIL t1_underrun: got %0d pulses required 0", ur_a - ur0); end
        n_tests++; if (a_dout !== 1'b1) begin n_fail++; $display("FAIL t1_idle_dout: got %b required 1", a_dout); end
    endtask

    task automatic test_bps1();
        int base = cap_b.size();
        int fd0 = fd_b, d;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        q.push_back(8'hA5);
        exp = frame_model(q, 1, 1);
        push(1, 8'hA5, 1'b1);
        idle(1);
        wait_frame(1, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t2_timeout: busy got %b required frame end", b_busy); end
        d = first_diff(1, base, exp);
        n_tests++; if (d >= 0) begin n_fail++;
            $display("FAIL t2_frame: first diff at cycle %0d, captured %0d cycles required %0d", d, cap_b.size() - base, exp.size()); end
        n_tests++; if (fd_b - fd0 != 1) begin n_fail++; $display("FAIL t2_frame_done: got %0d pulses required 1", fd_b - fd0); end
    endtask

    task automatic test_full_start();
        int base = cap_a.size();
        int fd0 = fd_a, ur0 = ur_a, pt0 = push_to, d;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        for (int i = 0; i < 17; i++) q.push_back(8'($urandom_range(0, 255)));
        exp = frame_model(q, 2, 4);
        for (int i = 0; i < 16; i++) push(0, q[i], 1'b0);
        @(negedge clk);
        idle_now(0);
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL t3_ready_full: got %b required 0", a_ready); end
        push(0, q[16], 1'b1);
        idle(0);
        wait_frame(0, ok);
        n_tests++; if (!ok || push_to != pt0) begin n_fail++; $display("FAIL t3_timeout: frame_ok=%b push_timeouts=%0d required 1 0", ok, push_to - pt0); end
        d = first_diff(0, base, exp);
        n_tests++; if (d >= 0) begin n_fail++;
            $display("FAIL t3_frame: first diff at cycle %0d, captured %0d cycles required %0d", d, cap_a.size() - base, exp.size()); end
        n_tests++; if (fd_a - fd0 != 1 || ur_a - ur0 != 0) begin n_fail++;
            $display("FAIL t3_pulses: frame_done %0d underrun %0d required 1 0", fd_a - fd0, ur_a - ur0); end
    endtask

    task automatic test_no_cutthrough();
        int base, bad = 0, d;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 255)));
        exp = frame_model(q, 2, 4);
        push(0, q[0], 1'b0);
        push(0, q[1], 1'b0);
        idle(0);
        repeat (100) begin
            @(negedge clk);
            if (a_busy !== 1'b0 || a_dout !== 1'b1) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL t4_hold: %0d cycles busy or low, required 0", bad); end
        base = cap_a.size();
        push(0, q[2], 1'b1);
        idle(0);
        wait_frame(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t4_timeout: busy got %b required frame end", a_busy); end
        d = first_diff(0, base, exp);
        n_tests++; if (d >= 0) begin n_fail++;
            $display("FAIL t4_frame: first diff at cycle %0d, captured %0d cycles required %0d", d, cap_a.size() - base, exp.size()); end
    endtask

    task automatic test_underrun();
        int base = cap_a.size();
        int fd0 = fd_a, ur0 = ur_a, bad = 0, d;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom_range(0, 255)));
        exp = frame_model(q, 2, 4);
        for (int i = 0; i < 16; i++) push(0, q[i], 1'b0);
        idle(0);
        wait_frame(0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL t5_timeout: busy got %b required frame end", a_busy); end
        d = first_diff(0, base, exp);
        n_tests++; if (d >= 0) begin n_fail++;
            $display("FAIL t5_frame: first diff at cycle %0d, captured %0d cycles required %0d", d, cap_a.size() - base, exp.size()); end
        n_tests++; if (ur_a - ur0 != 1) begin n_fail++; $display("FAIL t5_underrun: got %0d pulses required 1", ur_a - ur0); end
        n_tests++; if (fd_a - fd0 != 1) begin n_fail++; $display("FAIL t5_frame_done: got %0d pulses required 1", fd_a - fd0); end
        repeat (50) begin
            @(negedge clk);
            if (a_busy !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0 || a_ready !== 1'b1) begin n_fail++;
            $display("FAIL t5_after: busy cycles %0d ready %b required 0 1", bad, a_ready); end
    endtask

    task automatic test_reset_mid();
        int base, bad = 0, t = 0, d, fd0;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        push(0, 8'h3C, 1'b1);
        push(0, 8'h5A, 1'b1);
        idle(0);
        while (a_busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL t6_start: busy got %b required 1", a_busy); end
        // Cycle 41 of the frame lies in DATA slot 2 (32 SOF cycles + 2 slots of 4).
        repeat (41) @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        n_tests++; if (a_dout !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) begin n_fail++;
            $display("FAIL t6_reset: dout %b busy %b ready %b required 1 0 1", a_dout, a_busy, a_ready); end
        a_rst = 1'b0;
        fd0 = fd_a;
        repeat (60) begin
            @(negedge clk);
            if (a_busy !== 1'b0) bad++;
        end
        n_tests++; if (bad != 0 || fd_a != fd0) begin n_fail++;
            $display("FAIL t6_discard: busy cycles %0d frame_done %0d required 0 0", bad, fd_a - fd0); end
        q.push_back(8'($urandom_range(0, 255)));
        exp = frame_model(q, 2, 4);
        base = cap_a.size();
        push(0, q[0], 1'b1);
        idle(0);
        wait_frame(0, ok);
        d = first_diff(0, base, exp);
        n_tests++; if (!ok || d >= 0) begin n_fail++;
            $display("FAIL t6_new_frame: ok %b first diff %0d captured %0d required %0d", ok, d, cap_a.size() - base, exp.size()); end
    endtask

    task automatic test_back_to_back();
        int base = cap_a.size();
        int fd0 = fd_a, d, n1, n2;
        bit ok1, ok2;
        byte_q_t q1, q2;
        bitq_t exp, e2;
        n1 = $urandom_range(1, 6);
        n2 = $urandom_range(1, 6);
        for (int i = 0; i < n1; i++) q1.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < n2; i++) q2.push_back(8'($urandom_range(0, 255)));
        exp = frame_model(q1, 2, 4);
        e2  = frame_model(q2, 2, 4);
        foreach (e2[i]) exp.push_back(e2[i]);
        for (int i = 0; i < n1; i++) push(0, q1[i], i == n1 - 1);
        for (int i = 0; i < n2; i++) push(0, q2[i], i == n2 - 1);
        idle(0);
        wait_frame(0, ok1);
        wait_frame(0, ok2);
        n_tests++; if (!ok1 || !ok2) begin n_fail++; $display("FAIL b2b_timeout: frames seen %b%b required 11", ok1, ok2); end
        d = first_diff(0, base, exp);
        n_tests++; if (d >= 0) begin n_fail++;
            $display("FAIL b2b_frames: first diff at cycle %0d, captured %0d cycles required %0d", d, cap_a.size() - base, exp.size()); end
        n_tests++; if (fd_a - fd0 != 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d pulses required 2", fd_a - fd0); end
    endtask

    task automatic test_random_frames(input int sel, input int iters);
        int base, d, n, fd0, ur0;
        bit ok;
        byte_q_t q;
        bitq_t exp;
        for (int it = 0; it < iters; it++) begin
            q.delete();
            n = $urandom_range(1, (sel == 0) ? 12 : 8);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
            exp = (sel == 0) ? frame_model(q, 2, 4) : frame_model(q, 1, 1);
            base = cap_size(sel);
            fd0 = (sel == 0) ? fd_a : fd_b;
            ur0 = (sel == 0) ? ur_a : ur_b;
            for (int i = 0; i < n; i++) begin
                int gap = $urandom_range(0, 2);
                if (gap > 0) begin
                    idle(sel);
                    repeat (gap - 1) @(negedge clk);
                end
                push(sel, q[i], i == n - 1);
            end
            idle(sel);
            wait_frame(sel, ok);
            d = first_diff(sel, base, exp);
            n_tests++; if (!ok || d >= 0) begin n_fail++;
                $display("FAIL rand_frame dut%0d iter %0d: ok %b first diff %0d captured %0d required %0d",
                         sel, it, ok, d, cap_size(sel) - base, exp.size()); end
            n_tests++;
            if (((sel == 0) ? fd_a : fd_b) - fd0 != 1 || ((sel == 0) ? ur_a : ur_b) - ur0 != 0) begin n_fail++;
                $display("FAIL rand_pulses dut%0d iter %0d: frame_done %0d underrun %0d required 1 0", sel, it,
                         ((sel == 0) ? fd_a : fd_b) - fd0, ((sel == 0) ? ur_a : ur_b) - ur0); end
        end
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_valid = 1'b0; a_last = 1'b0; a_data = '0;
        b_valid = 1'b0; b_last = 1'b0; b_data = '0;
        test_reset();
        test_single_byte();
        test_bps1();
        test_full_start();
        test_no_cutthrough();
        test_underrun();
        test_reset_mid();
        test_back_to_back();
        test_random_frames(0, 4);
        test_random_frames(1, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
